debug_scan_port: RTL
====================

Name: debug_scan_port

Overview:
Parametrised successor to the top-level debug shift interface. Brings the external debug_clock, debug_strobe and debug_data_in pins into the core clock domain. Captures a STATE_WIDTH-bit snapshot of core state and shifts it out serially. Also shifts in a command word that gives run, halt and single-step control over the core via a clock-enable output.

Parameters:
STATE_WIDTH, 321, width of the captured state vector (allstate).
SYNC_STAGES, 2, synchroniser flops per debug pin (minimum 2).
CMD_WIDTH, 8, width of the serially loaded command word.

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
state_in  input  STATE_WIDTH  core state to snapshot.
debug_clock  input  1  asynchronous serial clock pin.
debug_strobe  input  1  asynchronous capture/commit pin.
debug_data_in  input  1  asynchronous serial command data pin.
debug_data  output  1  serial state data; MSB of the shift register.
core_enable  output  1  clock enable to the core.
capture_count  output  16  number of strobes taken, wrapping.

Behaviour:
- Reset values:
  - shift register all ones, so debug_data=1.
  - cmd shift register = 0.
  - bit counter = 0.
  - capture_count = 0.
  - FSM = RUN, so core_enable=1.
- Synchronisation:
  - Each pin passes through SYNC_STAGES flops.
  - A rising edge of debug_clock is detected as sync=1 and previous=0.
  - Edge takes effect on the clock edge SYNC_STAGES+1 cycles after the pin transition.
  - Strobe and data are sampled from their synchronised values in that same cycle.
- Edge with strobe=1 (capture/commit):
  - shift register <= state_in, using the value present in that cycle.
  - capture_count += 1, wrapping 0xFFFF -> 0.
  - If bit counter >= CMD_WIDTH, decode cmd shift register; otherwise the command is discarded.
  - Bit counter <= 0.
- Edge with strobe=0 (shift):
  - shift register <= {shift[STATE_WIDTH-2:0], 1}.
  - cmd <= {cmd[CMD_WIDTH-2:0], debug_data_in}.
  - Bit counter increments and saturates at CMD_WIDTH.
  - Shifting past STATE_WIDTH bits yields ones on debug_data.
- No edge: all registers hold.
- Commands take effect the cycle after the commit edge:
  - 0x00 NOP.
  - 0x01 HALT.
  - 0x02 RUN.
  - 0x03 STEP.
  - Any other value is ignored.
- FSM:
  - RUN: core_enable=1. HALT -> HALT. STEP -> HALT (acts as halt). RUN/NOP -> stay.
  - HALT: core_enable=0. RUN -> RUN. STEP -> STEP.
  - STEP: core_enable=1 for exactly one cycle, then unconditionally HALT. Any commit landing in that cycle is processed against HALT on the next cycle; it is not lost.
- Capture is taken before the command takes effect. A HALT+capture strobe snapshots the state of the cycle the strobe was detected in.
- Reset asserted mid-shift or mid-step:
  - All state returns to reset values on the next edge.
  - A partial command is dropped.
  - core_enable=1.
- debug_data is a register output and changes only on detected shift or capture edges.

Optional Feature:
- Macro: DEBUG_SCAN_SEQ_EN.
- Defined:
  - The shift register is STATE_WIDTH+8 bits wide.
  - Capture loads {capture_count_next[7:0], state_in}, where capture_count_next is the post-increment value.
  - The first 8 bits out are the capture sequence number, MSB first, followed by the state.
- Undefined:
  - The shift register is exactly STATE_WIDTH bits.
  - No sequence byte is output.

Test Plan:
1. Reset, then STATE_WIDTH=16, state_in=0xA5C3. Strobe edge, then 16 shift edges -> debug_data reads 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. A 17th shift reads 1. capture_count=1.
2. Shift in 0x01 MSB-first (8 edges), then strobe -> core_enable falls exactly 1 cycle after the commit edge is detected and stays 0.
3. From HALT, shift 0x03 and strobe -> core_enable high for exactly one cycle, then 0. Repeat 3 times -> 3 single pulses. Then 0x02 -> core_enable stays 1.
4. Shift only 5 bits of 0x01, then strobe -> command discarded, core_enable stays 1, capture still taken.
5. Pulse debug_clock with period under SYNC_STAGES cycles and glitches shorter than 1 cycle -> no spurious shifts. Clean edges are counted exactly once each.
6. Assert reset after 4 of 8 command bits have been shifted -> debug_data=1, capture_count=0, core_enable=1. Then send a full 0x01 -> halts normally.
   - With DEBUG_SCAN_SEQ_EN: after 2 strobes, the first 8 bits out are 0x02.

Source files
------------

// File: rtl/debug_scan_port.sv
// Debug scan port: synchronises the external debug pins, shifts out a core-state snapshot and
// loads run/halt/step commands. Define DEBUG_SCAN_SEQ_EN to prefix each snapshot with a sequence byte.
module debug_scan_port #(
  parameter int unsigned STATE_WIDTH = 321,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CMD_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [STATE_WIDTH-1:0] state_in,
  input  logic                   debug_clock,
  input  logic                   debug_strobe,
  input  logic                   debug_data_in,
  output logic                   debug_data,
  output logic                   core_enable,
  output logic [15:0]            capture_count
);

`ifdef DEBUG_SCAN_SEQ_EN
  localparam int unsigned SHIFT_W = STATE_WIDTH + 8;
`else
  localparam int unsigned SHIFT_W = STATE_WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(CMD_WIDTH + 1);
  localparam int unsigned CC_W  = 16;

  localparam logic [CMD_WIDTH-1:0] CMD_HALT = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] CMD_RUN  = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] CMD_STEP = CMD_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_stb_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;

  logic [SHIFT_W-1:0]     r_shift;
  logic [CMD_WIDTH-1:0]   r_cmd;
  logic [CNT_W-1:0]       r_bitcnt;
  logic [CC_W-1:0]        r_capture_count;
  logic                   r_pend_valid;
  logic [CMD_WIDTH-1:0]   r_pend_cmd;
  state_e                 r_state;
  logic                   r_core_enable;

  logic                   w_edge;
  logic                   w_capture;
  logic                   w_shift;
  logic                   w_commit;
  logic [CC_W-1:0]        w_cc_next;
  state_e                 w_state_next;
  logic                   w_consume;

  // Pin synchronisers plus previous-value flop for rising-edge detection of debug_clock
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_sync <= '0;
      r_stb_sync <= '0;
      r_dat_sync <= '0;
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], debug_clock};
      r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], debug_strobe};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], debug_data_in};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge    = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
  assign w_capture = w_edge &  r_stb_sync[SYNC_STAGES-1];
  assign w_shift   = w_edge & ~r_stb_sync[SYNC_STAGES-1];
  assign w_commit  = w_capture && (r_bitcnt >= CNT_W'(CMD_WIDTH));
  assign w_cc_next = r_capture_count + CC_W'(1);

  // Snapshot/shift datapath and command word assembly
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift         <= '1;
      r_cmd           <= '0;
      r_bitcnt        <= '0;
      r_capture_count <= '0;
    end else if (w_capture) begin
`ifdef DEBUG_SCAN_SEQ_EN
      r_shift         <= {w_cc_next[7:0], state_in};
`else
      r_shift         <= state_in;
`endif
      r_capture_count <= w_cc_next;
      r_bitcnt        <= '0;
    end else if (w_shift) begin
      r_shift <= {r_shift[SHIFT_W-2:0], 1'b1};
      r_cmd   <= {r_cmd[CMD_WIDTH-2:0], r_dat_sync[SYNC_STAGES-1]};
      if (r_bitcnt < CNT_W'(CMD_WIDTH)) begin
        r_bitcnt <= r_bitcnt + CNT_W'(1);
      end
    end
  end

  // A committed command waits here until the FSM is in a state that can accept it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_cmd   <= '0;
    end else if (w_commit) begin
      r_pend_valid <= 1'b1;
      r_pend_cmd   <= r_cmd;
    end else if (w_consume) begin
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_core_enable <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_core_enable <= (w_state_next != ST_HALT);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (r_pend_valid) begin
          w_consume = 1'b1;
          if (r_pend_cmd == CMD_HALT || r_pend_cmd == CMD_STEP) begin
            w_state_next = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (r_pend_valid) begin
          w_consume = 1'b1;
          if (r_pend_cmd == CMD_RUN) begin
            w_state_next = ST_RUN;
          end else if (r_pend_cmd == CMD_STEP) begin
            w_state_next = ST_STEP;
          end
        end
      end
      ST_STEP: w_state_next = ST_HALT;
      default: w_state_next = ST_RUN;
    endcase
  end

  assign debug_data    = r_shift[SHIFT_W-1];
  assign core_enable   = r_core_enable;
  assign capture_count = r_capture_count;

endmodule
